// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, state type and ignore-code helper for the PS/2 keyboard receiver
package ps2_pkg;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;
  localparam int PS2_IGNORE_N = 6;
  localparam logic [8*PS2_IGNORE_N-1:0] PS2_IGNORE = {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;
  function automatic logic ps2_is_ignored(input logic [7:0] b);
    ps2_is_ignored = 1'b0;
    for (int i = 0; i < PS2_IGNORE_N; i++)
      if (b == PS2_IGNORE[i*8 +: 8]) ps2_is_ignored = 1'b1;
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and filters the PS/2 lines and deserialises 11-bit frames
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err_parity,
  output logic       err_frame
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] clk_s, dat_s;
  logic clk_f, flip, strobe, din;
  logic [7:0] flt_cnt;
  ps2_rx_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sr, sr_n;
  logic par_ok, par_ok_n, valid_n, perr_n, ferr_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  assign din = dat_s[1];
  assign flip = (clk_s[1] != clk_f) && (flt_cnt == 8'(FILTER_LEN - 1));
  assign strobe = flip && clk_f;
  assign rx_byte = sr;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_f <= 1'b1;
      flt_cnt <= '0;
      state <= IDLE;
      bit_cnt <= '0;
      sr <= '0;
      par_ok <= 1'b0;
      to_cnt <= '0;
      byte_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      flt_cnt <= (clk_s[1] == clk_f || flip) ? '0 : flt_cnt + 8'd1;
      clk_f <= flip ? ~clk_f : clk_f;
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      sr <= sr_n;
      par_ok <= par_ok_n;
      to_cnt <= to_cnt_n;
      byte_valid <= valid_n;
      err_parity <= perr_n;
      err_frame <= ferr_n;
    end
  end
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    sr_n = sr;
    par_ok_n = par_ok;
    to_cnt_n = (state == IDLE || strobe) ? '0 : to_cnt + 1'b1;
    valid_n = 1'b0;
    perr_n = 1'b0;
    ferr_n = 1'b0;
    if (state != IDLE && !strobe && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
      state_n = IDLE;
      ferr_n = 1'b1;
    end else if (strobe) begin
      case (state)
        IDLE: begin
          ferr_n = din;
          state_n = din ? IDLE : DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          sr_n = {din, sr[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_ok_n = ^{sr, din};
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          ferr_n = !din;
          perr_n = din && !par_ok;
          valid_n = din && par_ok;
        end
      endcase
    end
  end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: folds E0/F0/E1 prefixes of scan-code set 2 bytes into toggle-strobed key events
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  output logic [10:0] ps2_key,
  output logic        err_parity,
  output logic        err_frame
);
  logic [7:0] rx_byte;
  logic byte_valid, ext, brk;
  logic [2:0] skip;
  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_frame (
    .clk_sys(clk_sys),
    .reset(reset),
    .ps2_clk(ps2_kbd_clk),
    .ps2_data(ps2_kbd_data),
    .rx_byte(rx_byte),
    .byte_valid(byte_valid),
    .err_parity(err_parity),
    .err_frame(err_frame)
  );
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_key <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      skip <= '0;
    end else if (err_parity || err_frame) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      if (skip != 3'd0) skip <= skip - 3'd1;
      else if (rx_byte == PS2_PFX_PAUSE) skip <= PS2_PAUSE_SKIP;
      else if (rx_byte == PS2_PFX_EXT) ext <= 1'b1;
      else if (rx_byte == PS2_PFX_BRK) brk <= 1'b1;
      else begin
        if (!ps2_is_ignored(rx_byte)) ps2_key <= {~ps2_key[10], ~brk, ext, rx_byte};
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: table-driven frame vectors plus hand-written latency, glitch and timeout sequences
module tb_ps2_kbd_rx;
  localparam int F = 8;
  localparam int T = 300;
  localparam int H = 20;
  typedef struct {
    logic [7:0]  b;
    logic        bp;
    logic        bs;
    logic [10:0] key;
    int          perr;
    int          ferr;
  } vec_t;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic ps2_kbd_clk = 1'b1;
  logic ps2_kbd_data = 1'b1;
  logic [10:0] ps2_key;
  logic err_parity, err_frame;
  int vec_cnt = 0, bad_cnt = 0;
  int perr_cnt = 0, ferr_cnt = 0, upd_cnt = 0;
  logic [10:0] last_key = '0;
  vec_t tbl[$];
  always #5 clk_sys = ~clk_sys;
  ps2_kbd_rx #(.FILTER_LEN(F), .TIMEOUT_CYC(T)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ps2_kbd_clk(ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .ps2_key(ps2_key),
    .err_parity(err_parity),
    .err_frame(err_frame)
  );
  always @(negedge clk_sys)
    if (!reset) begin
      perr_cnt += int'(err_parity);
      ferr_cnt += int'(err_frame);
      if (ps2_key !== last_key) begin
        upd_cnt++;
        last_key = ps2_key;
      end
    end
  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bit_out(input logic b);
    ps2_kbd_data = b;
    repeat (H) @(negedge clk_sys);
    ps2_kbd_clk = 1'b0;
    repeat (H) @(negedge clk_sys);
    ps2_kbd_clk = 1'b1;
  endtask
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) bit_out(f[i]);
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b, input logic bp, input logic bs);
    return {~bs, (~^b) ^ bp, b, 1'b0};
  endfunction
  task automatic add(input logic [7:0] b, input logic bp, input logic bs, input logic [10:0] key,
                     input int perr, input int ferr);
    vec_t v;
    v.b = b; v.bp = bp; v.bs = bs; v.key = key; v.perr = perr; v.ferr = ferr;
    tbl.push_back(v);
  endtask
  initial begin
    int p0, f0, u0, c;
    logic [10:0] prev;
    add(8'hF0, 0, 0, 11'h61C, 0, 0);
    add(8'h1C, 0, 0, 11'h01C, 0, 0);
    add(8'hE0, 0, 0, 11'h01C, 0, 0);
    add(8'h6B, 0, 0, 11'h76B, 0, 0);
    add(8'hE0, 0, 0, 11'h76B, 0, 0);
    add(8'hF0, 0, 0, 11'h76B, 0, 0);
    add(8'h6B, 0, 0, 11'h16B, 0, 0);
    add(8'h1C, 1, 0, 11'h16B, 1, 0);
    add(8'h29, 0, 0, 11'h629, 0, 0);
    add(8'hE0, 0, 0, 11'h629, 0, 0);
    add(8'h1C, 0, 1, 11'h629, 0, 1);
    add(8'h29, 0, 0, 11'h229, 0, 0);
    add(8'hFA, 0, 0, 11'h229, 0, 0);
    add(8'hAA, 0, 0, 11'h229, 0, 0);
    add(8'hF0, 0, 0, 11'h229, 0, 0);
    add(8'hAA, 0, 0, 11'h229, 0, 0);
    add(8'h29, 0, 0, 11'h629, 0, 0);
    add(8'hE1, 0, 0, 11'h629, 0, 0);
    add(8'h14, 0, 0, 11'h629, 0, 0);
    add(8'h77, 0, 0, 11'h629, 0, 0);
    add(8'hE1, 0, 0, 11'h629, 0, 0);
    add(8'hF0, 0, 0, 11'h629, 0, 0);
    add(8'h14, 0, 0, 11'h629, 0, 0);
    add(8'hF0, 0, 0, 11'h629, 0, 0);
    add(8'h77, 0, 0, 11'h629, 0, 0);
    add(8'h1C, 0, 0, 11'h21C, 0, 0);
    add(8'hF0, 0, 0, 11'h21C, 0, 0);
    add(8'hE0, 0, 0, 11'h21C, 0, 0);
    add(8'h6B, 0, 0, 11'h56B, 0, 0);
    repeat (4) @(posedge clk_sys);
    #1;
    chk("reset_key", int'(ps2_key), 0);
    chk("reset_perr", int'(err_parity), 0);
    chk("reset_ferr", int'(err_frame), 0);
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    send_bits(frame(8'h1C, 0, 0), 10);
    ps2_kbd_data = 1'b1;
    repeat (H) @(negedge clk_sys);
    ps2_kbd_clk = 1'b0;
    repeat (F + 2) @(posedge clk_sys);
    #1;
    chk("lat_early_key", int'(ps2_key), 0);
    @(posedge clk_sys);
    #1;
    chk("lat_key", int'(ps2_key), 'h61C);
    repeat (H) @(negedge clk_sys);
    ps2_kbd_clk = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("first_errs", perr_cnt + ferr_cnt, 0);
    chk("first_upd", upd_cnt, 1);
    prev = 11'h61C;
    for (int i = 0; i < tbl.size(); i++) begin
      p0 = perr_cnt; f0 = ferr_cnt; u0 = upd_cnt;
      send_bits(frame(tbl[i].b, tbl[i].bp, tbl[i].bs), 11);
      @(posedge clk_sys);
      #1;
      chk($sformatf("v%0d_key", i), int'(ps2_key), int'(tbl[i].key));
      chk($sformatf("v%0d_perr", i), perr_cnt - p0, tbl[i].perr);
      chk($sformatf("v%0d_ferr", i), ferr_cnt - f0, tbl[i].ferr);
      chk($sformatf("v%0d_upd", i), upd_cnt - u0, int'(tbl[i].key != prev));
      prev = tbl[i].key;
    end
    f0 = ferr_cnt; u0 = upd_cnt;
    @(negedge clk_sys);
    ps2_kbd_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_kbd_clk = 1'b1;
    repeat (3 * F) @(posedge clk_sys);
    #1;
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_upd", upd_cnt - u0, 0);
    f0 = ferr_cnt;
    bit_out(1'b1);
    @(posedge clk_sys);
    #1;
    chk("start_high_ferr", ferr_cnt - f0, 1);
    chk("start_high_key", int'(ps2_key), 'h56B);
    f0 = ferr_cnt;
    send_bits(frame(8'h29, 0, 0), 5);
    c = 0;
    while (c < 2 * T && !err_frame) begin
      @(posedge clk_sys);
      #1;
      c++;
    end
    chk("timeout_seen", int'(err_frame), 1);
    chk("timeout_window", int'(H + c >= T && H + c <= T + F + H), 1);
    repeat (4) @(posedge clk_sys);
    #1;
    chk("timeout_ferr", ferr_cnt - f0, 1);
    chk("timeout_key", int'(ps2_key), 'h56B);
    send_bits(frame(8'h29, 0, 0), 11);
    @(posedge clk_sys);
    #1;
    chk("after_timeout_key", int'(ps2_key), 'h229);
    chk("after_timeout_ferr", ferr_cnt - f0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the Spectrum key-matrix block. It samples the raw PS/2 clock and data lines and deserialises scan-code set 2 frames. It folds the E0 (extended) and F0 (break) prefixes into each key event and presents every event on the 11-bit toggle-strobed ps2_key bus that the matrix block consumes. Parity and framing errors are flagged, never forwarded.

Parameters:
FILTER_LEN, 8, consecutive identical clk_sys samples needed before the filtered PS/2 clock changes level (range 2..255)
TIMEOUT_CYC, 100000, clk_sys cycles allowed between two falling edges inside a frame before the frame is aborted

Ports:
clk_sys  in  1  system clock; the single clock of the block
reset  in  1  synchronous, active-high reset
ps2_kbd_clk  in  1  raw PS/2 clock line, asynchronous, idle high
ps2_kbd_data  in  1  raw PS/2 data line, asynchronous, idle high
ps2_key  out  11  [10] toggles once per event; [9] 1 = make, 0 = break; [8] extended (E0 prefix); [7:0] scan code
err_parity  out  1  one-cycle pulse on a parity failure
err_frame  out  1  one-cycle pulse on bad start bit, bad stop bit, or timeout

Behaviour:
- Interface: one clock, clk_sys; reset is synchronous and active-high.
- Reset values: ps2_key = 0, err_parity = 0, err_frame = 0, FSM = IDLE, prefix flags and skip counter cleared, filter state = high.
- Reset mid-frame discards the partial byte. The downstream block is reset on the same reset, so the toggle returning to 0 needs no special handling.
- Input conditioning:
  - 2-FF synchroniser on both lines.
  - Filtered clock changes level only after FILTER_LEN equal consecutive samples.
  - A falling edge of the filtered clock is the bit strobe; data is sampled from the synchronised data line on that cycle.
- Frame FSM (11 bits):
  - IDLE: on a strobe with data = 0 go to DATA with bit count 0. A strobe with data = 1 stays in IDLE and pulses err_frame.
  - DATA: shift in LSB first; after 8 strobes go to PARITY.
  - PARITY: check odd parity over the 8 data bits plus the parity bit; latch the result; go to STOP.
  - STOP: on the strobe, if data = 0 pulse err_frame. Otherwise, if parity failed, pulse err_parity. Otherwise assert byte_valid for one cycle. In all three cases return to IDLE.
  - Timeout: in any state other than IDLE, a counter is cleared on each strobe. If it reaches TIMEOUT_CYC, return to IDLE and pulse err_frame.
- Byte decoder, acting on byte_valid:
  - Skip counter non-zero: decrement it; emit nothing.
  - E1: load skip counter with 7, so the pause sequence is swallowed; no event.
  - E0: set ext. F0: set brk. No event for either.
  - AA, FA, EE, FE, 00, FF: no event; clear ext and brk.
  - Any other byte: ps2_key <= {~ps2_key[10], ~brk, ext, byte}; clear ext and brk.
- Any parity or frame error clears ext and brk. The skip counter is kept.
- Latency: ps2_key updates exactly 2 clk_sys cycles after the cycle in which the stop-bit strobe is detected. An error pulse occurs 1 cycle after that strobe.
- ps2_key holds its value between events. The E0/F0 order is fixed as E0 F0 code; a stray F0 E0 still decodes as ext = 1, brk = 1.

Decomposition:
- Package ps2_pkg:
  - constants PS2_PFX_EXT = 8'hE0, PS2_PFX_BRK = 8'hF0, PS2_PFX_PAUSE = 8'hE1, PS2_PAUSE_SKIP = 7
  - the ignore-code list
  - typedef enum {IDLE, DATA, PARITY, STOP} ps2_rx_state_t
- Sub-module ps2_frame_rx: synchroniser, filter, frame FSM and timeout. Outputs byte, byte_valid, err_parity, err_frame.
- Top ps2_kbd_rx: prefix and skip decoder plus the ps2_key register.

Test Plan:
1. Reset, then frame 0x1C (odd parity bit 0) -> ps2_key = 11'h61C two cycles after the stop strobe; no error pulses.
2. Continue with frames F0, 1C -> ps2_key = 11'h01C (toggle 0, break); exactly one update across both frames.
3. Frames E0 6B, then E0 F0 6B -> ps2_key = 11'h76B, then 11'h16B.
4. Frame 0x1C with parity bit 1 -> single err_parity pulse; ps2_key unchanged. A following frame 0x29 -> toggled value with [9:0] = 10'h229 (ext clear).
5. Start bit plus 4 data bits, then the clock is held high -> err_frame after TIMEOUT_CYC cycles; FSM in IDLE. A following 0x29 frame is decoded correctly.
6. With FILTER_LEN = 8, a 3-cycle low glitch on ps2_kbd_clk -> no strobe. Pause sequence E1 14 77 E1 F0 14 F0 77 -> no ps2_key change.
